// File: rtl/seq_mem_arbiter.sv
// ---------------------------------------------------------------------------
// seq_mem_arbiter
//
// Shares the single unified Y86 memory between the SEQ fetch stage (IF,
// instruction reads) and the memory stage (DM, data reads/writes). Each
// requester holds req until it sees a one-cycle ack. One transaction at a
// time is driven onto the registered memory port. If the memory never
// answers, the transaction is aborted with bus_err and all-ones read data.
//
// Parameters:
//   ADDR_W   address width of all address ports
//   DATA_W   data width of all data ports
//   TIMEOUT  BUSY cycles to wait for mem_ack before aborting (2..255)
//
// Ports:
//   CLK, RESET          rising-edge clock, asynchronous active-low reset
//   if_req/if_addr      fetch request and address
//   if_ack/if_rdata     fetch completion pulse and fetched word
//   dm_req/dm_we/dm_addr/dm_wdata
//                       data-stage request, direction, address, write data
//   dm_ack/dm_rdata     data-stage completion pulse and read data
//   bus_err             pulses with the ack of a timed-out transaction
//   mem_req/mem_we/mem_addr/mem_wdata
//                       registered request towards the memory
//   mem_ack/mem_rdata   memory completion pulse and read data
//
// Build option:
//   SEQ_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                           between IF and DM instead of DM always winning.
// ---------------------------------------------------------------------------
module seq_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Last BUSY cycle before the transaction is abandoned; the counter
    // starts at 0 on grant, so mem_req stays high for TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic       own;
    logic [7:0] timeout_cnt;
    logic       grant_dm;
    logic       timeout_hit;

    // Winner selection for the IDLE grant. A lone requester always wins;
    // on a conflict DM wins, or with round-robin the previous non-owner wins
    // (OWN resets to IF, so the first conflict after reset still goes to DM).
    always_comb begin
        grant_dm = 1'b0;
        if (dm_req && if_req) begin
`ifdef SEQ_ARB_ROUND_ROBIN_EN
            grant_dm = (own == OWN_IF);
`else
            grant_dm = 1'b1;
`endif
        end else begin
            grant_dm = dm_req;
        end
    end

    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

    // Transaction FSM and all registered outputs. Acks and bus_err are
    // set on the BUSY->DONE transition so they are high for exactly the
    // DONE cycle, and are cleared by default on every other edge.
    // mem_ack outside BUSY falls through untouched, so it is ignored.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            own         <= OWN_IF;
            timeout_cnt <= '0;
            if_ack      <= 1'b0;
            if_rdata    <= '0;
            dm_ack      <= 1'b0;
            dm_rdata    <= '0;
            bus_err     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            if_ack  <= 1'b0;
            dm_ack  <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        state       <= BUSY;
                        mem_req     <= 1'b1;
                        timeout_cnt <= '0;
                        if (grant_dm) begin
                            own       <= OWN_DM;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end else begin
                            own       <= OWN_IF;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (own == OWN_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            dm_ack <= 1'b1;
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        bus_err <= 1'b1;
                        if (own == OWN_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= '1;
                        end else begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= '1;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seq_mem_arbiter
//
// Directed bench for seq_mem_arbiter: reset state, request conflicts, single
// IF read, DM write and read-back, timeout with bus_err, reset in the middle
// of a transaction and a stray mem_ack in IDLE. The memory side is driven by
// hand from the stimulus sequence. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_seq_mem_arbiter;

`ifdef SEQ_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        CLK;
    logic        RESET;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int busyCycles;

    seq_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(16)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .bus_err  (bus_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    // 10-unit clock period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge and settle to the sampling point.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive both requester ports in one go.
    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic dmReq, input logic dmWe,
                                 input logic [31:0] dmAddr, input logic [31:0] dmWdata);
        if_req   = ifReq;
        if_addr  = ifAddr;
        dm_req   = dmReq;
        dm_we    = dmWe;
        dm_addr  = dmAddr;
        dm_wdata = dmWdata;
    endtask

    // Memory answers in the current cycle; returns in the DONE cycle.
    task automatic memRespond(input logic [31:0] data);
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        RESET     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // ---------------- reset state ----------------
        #12;
        checkOutput("rst_mem_req",   {31'd0, mem_req},   32'd0);
        checkOutput("rst_mem_we",    {31'd0, mem_we},    32'd0);
        checkOutput("rst_mem_addr",  mem_addr,           32'd0);
        checkOutput("rst_mem_wdata", mem_wdata,          32'd0);
        checkOutput("rst_acks",      {29'd0, if_ack, dm_ack, bus_err}, 32'd0);
        checkOutput("rst_if_rdata",  if_rdata,           32'd0);
        checkOutput("rst_dm_rdata",  dm_rdata,           32'd0);
        tick();
        RESET = 1'b1;
        tick();

        // ---------------- conflict 1: DM wins, then IF ----------------
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h200, 32'h0);
        tick();
        checkOutput("c1_first_addr", mem_addr, 32'h200);
        checkOutput("c1_first_req",  {31'd0, mem_req}, 32'd1);
        memRespond(32'hAAAA0001);
        checkOutput("c1_dm_ack",   {31'd0, dm_ack}, 32'd1);
        checkOutput("c1_if_ack0",  {31'd0, if_ack}, 32'd0);
        checkOutput("c1_dm_rdata", dm_rdata, 32'hAAAA0001);
        dm_req = 1'b0;
        tick();
        checkOutput("c1_idle_req", {31'd0, mem_req}, 32'd0);
        tick();
        checkOutput("c1_second_addr", mem_addr, 32'h20);
        checkOutput("c1_second_req",  {31'd0, mem_req}, 32'd1);
        memRespond(32'hBBBB0002);
        checkOutput("c1_if_ack",   {31'd0, if_ack}, 32'd1);
        checkOutput("c1_if_rdata", if_rdata, 32'hBBBB0002);
        if_req = 1'b0;
        tick();

        // ---------------- single IF read, minimum latency ----------------
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("if_mem_req",  {31'd0, mem_req}, 32'd1);
        checkOutput("if_mem_addr", mem_addr, 32'h10);
        checkOutput("if_mem_we",   {31'd0, mem_we}, 32'd0);
        checkOutput("if_ack_early", {31'd0, if_ack}, 32'd0);
        memRespond(32'h30F40001);
        checkOutput("if_ack",      {31'd0, if_ack}, 32'd1);
        checkOutput("if_rdata",    if_rdata, 32'h30F40001);
        checkOutput("if_dm_ack0",  {31'd0, dm_ack}, 32'd0);
        checkOutput("if_bus_err0", {31'd0, bus_err}, 32'd0);
        checkOutput("if_req_drop", {31'd0, mem_req}, 32'd0);
        if_req = 1'b0;
        tick();
        checkOutput("if_ack_pulse", {31'd0, if_ack}, 32'd0);

        // ---------------- DM write ----------------
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
        tick();
        checkOutput("wr_mem_we",    {31'd0, mem_we}, 32'd1);
        checkOutput("wr_mem_addr",  mem_addr, 32'h100);
        checkOutput("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        memRespond(32'h12345678);
        checkOutput("wr_dm_ack",    {31'd0, dm_ack}, 32'd1);
        checkOutput("wr_dm_rdata",  dm_rdata, 32'hAAAA0001);
        dm_req = 1'b0;
        tick();

        // ---------------- DM read back ----------------
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        checkOutput("rd_mem_we",   {31'd0, mem_we}, 32'd0);
        memRespond(32'hDEADBEEF);
        checkOutput("rd_dm_ack",   {31'd0, dm_ack}, 32'd1);
        checkOutput("rd_dm_rdata", dm_rdata, 32'hDEADBEEF);
        checkOutput("rd_if_rdata", if_rdata, 32'h30F40001);
        dm_req = 1'b0;
        tick();

        // ---------------- conflict 2: previous owner is DM ----------------
        applyStimulus(1'b1, 32'h24, 1'b1, 1'b0, 32'h204, 32'h0);
        tick();
        checkOutput("c2_first_addr", mem_addr, RR ? 32'h24 : 32'h204);
        memRespond(32'hC0000024);
        checkOutput("c2_first_if_ack", {31'd0, if_ack}, RR ? 32'd1 : 32'd0);
        checkOutput("c2_first_dm_ack", {31'd0, dm_ack}, RR ? 32'd0 : 32'd1);
        if (RR) if_req = 1'b0;
        else    dm_req = 1'b0;
        tick();
        tick();
        checkOutput("c2_second_addr", mem_addr, RR ? 32'h204 : 32'h24);
        memRespond(32'hC0000204);
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();

        // ---------------- timeout ----------------
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        busyCycles = 0;
        while (mem_req === 1'b1 && busyCycles < 40) begin
            busyCycles++;
            tick();
        end
        checkOutput("to_busy_cycles", busyCycles, 32'd16);
        checkOutput("to_if_ack",   {31'd0, if_ack}, 32'd1);
        checkOutput("to_bus_err",  {31'd0, bus_err}, 32'd1);
        checkOutput("to_if_rdata", if_rdata, 32'hFFFFFFFF);
        if_req = 1'b0;
        tick();
        checkOutput("to_clear", {30'd0, if_ack, bus_err}, 32'd0);
        checkOutput("to_idle_req", {31'd0, mem_req}, 32'd0);

        // ---------------- reset in the middle of BUSY ----------------
        applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("rb_granted", {31'd0, mem_req}, 32'd1);
        tick();
        tick();
        RESET = 1'b0;
        #1;
        checkOutput("rb_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rb_mem_addr", mem_addr, 32'd0);
        checkOutput("rb_if_rdata", if_rdata, 32'd0);
        if_req = 1'b0;
        tick();
        tick();
        checkOutput("rb_no_ack", {30'd0, if_ack, dm_ack}, 32'd0);
        RESET = 1'b1;
        tick();
        applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("rb_fresh_addr", mem_addr, 32'h60);
        memRespond(32'h600D0060);
        checkOutput("rb_fresh_ack",   {31'd0, if_ack}, 32'd1);
        checkOutput("rb_fresh_rdata", if_rdata, 32'h600D0060);
        if_req = 1'b0;
        tick();

        // ---------------- stray mem_ack in IDLE ----------------
        memRespond(32'h55555555);
        checkOutput("st_mem_req",  {31'd0, mem_req}, 32'd0);
        checkOutput("st_acks",     {30'd0, if_ack, dm_ack}, 32'd0);
        checkOutput("st_if_rdata", if_rdata, 32'h600D0060);
        checkOutput("st_dm_rdata", dm_rdata, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
